// File: rtl/cdp_rdma_credit_sched.sv
// CDP read-DMA credit scheduler: admits read requests against latency-FIFO
// credits, tracks per-layer request count and flags layer completion.
module cdp_rdma_credit_sched #(
    parameter int unsigned LAT_DEPTH = 256,
    parameter int unsigned CNT_W     = 9
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             reg2dp_op_en,
    input  logic [23:0]      reg2dp_req_total,
    input  logic             ig_req_valid,
    input  logic [1:0]       ig_req_size,
    output logic             ig_req_ready,
    output logic             dma_req_valid,
    input  logic             dma_req_ready,
    input  logic             lat_fifo_pop,
    output logic             layer_done,
    output logic [CNT_W-1:0] credit_cnt,
    output logic [31:0]      perf_credit_stall,
    output logic             credit_err
);

    localparam int unsigned TOT_W  = 24;
    localparam int unsigned PERF_W = 32;
    localparam int unsigned EXT_W  = CNT_W + 1;
    localparam logic [EXT_W-1:0] LAT_EXT = EXT_W'(LAT_DEPTH);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e              state_q,      state_d;
    logic                op_en_dly_q,  op_en_dly_d;
    logic [CNT_W-1:0]    credit_q,     credit_d;
    logic                credit_err_q, credit_err_d;
    logic [TOT_W-1:0]    issued_q,     issued_d;
    logic [TOT_W-1:0]    total_q,      total_d;
    logic [PERF_W-1:0]   stall_q,      stall_d;
    logic                done_q,       done_d;

    logic                start;
    logic                in_run;
    logic                credit_ok;
    logic                gate;
    logic                accept;
    logic [EXT_W-1:0]    req_atoms;
    logic [EXT_W-1:0]    credit_sum;

    // Admission gate: only in RUN and only with enough credits for the whole request.
    assign start         = reg2dp_op_en & ~op_en_dly_q;
    assign in_run        = (state_q == ST_RUN);
    assign req_atoms     = EXT_W'(ig_req_size) + EXT_W'(1);
    assign credit_ok     = ({1'b0, credit_q} >= req_atoms);
    assign gate          = in_run & credit_ok;
    assign dma_req_valid = ig_req_valid & gate;
    assign ig_req_ready  = dma_req_ready & gate;
    assign accept        = ig_req_valid & ig_req_ready;

    assign layer_done        = done_q;
    assign credit_cnt        = credit_q;
    assign perf_credit_stall = stall_q;
    assign credit_err        = credit_err_q;

    // Next-state: layer FSM, credit accounting, request and stall counters.
    always_comb begin
        state_d      = state_q;
        op_en_dly_d  = reg2dp_op_en;
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        issued_d     = issued_q;
        total_d      = total_q;
        stall_d      = stall_q;
        credit_sum   = '0;

        // Spend credits on accept and recover one per pop in the same cycle.
        credit_sum = {1'b0, credit_q} - (accept ? req_atoms : EXT_W'(0))
                   + EXT_W'(lat_fifo_pop);
        if (credit_sum > LAT_EXT) begin
            credit_d     = LAT_CNT;
            credit_err_d = 1'b1;
        end else begin
            credit_d = credit_sum[CNT_W-1:0];
        end

        if (accept) begin
            issued_d = issued_q + TOT_W'(1);
        end

        if (in_run && ig_req_valid && !credit_ok && (stall_q != '1)) begin
            stall_d = stall_q + PERF_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    issued_d = '0;
                    stall_d  = '0;
                    total_d  = reg2dp_req_total;
                    state_d  = (reg2dp_req_total != '0) ? ST_RUN : ST_DRAIN;
                end
            end
            ST_RUN: begin
                if (accept && ((issued_q + TOT_W'(1)) == total_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (credit_q == LAT_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE);
    end

    // State and counter registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q      <= ST_IDLE;
            op_en_dly_q  <= 1'b0;
            credit_q     <= LAT_CNT;
            credit_err_q <= 1'b0;
            issued_q     <= '0;
            total_q      <= '0;
            stall_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_en_dly_q  <= op_en_dly_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
            issued_q     <= issued_d;
            total_q      <= total_d;
            stall_q      <= stall_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_cdp_rdma_credit_sched.sv
// Directed bench for cdp_rdma_credit_sched: a default-depth instance driven by
// a vector table and a single-layer sequence, and a depth-8 instance used for
// credit exhaustion and mid-layer reset.
module tb_cdp_rdma_credit_sched;

    logic clk;
    logic rstn_a, rstn_b;

    // Instance A: LAT_DEPTH=256
    logic        a_op_en;
    logic [23:0] a_total;
    logic        a_valid;
    logic [1:0]  a_size;
    logic        a_ig_ready;
    logic        a_dma_valid;
    logic        a_dma_ready;
    logic        a_pop;
    logic        a_done;
    logic [8:0]  a_credit;
    logic [31:0] a_stall;
    logic        a_err;

    // Instance B: LAT_DEPTH=8
    logic        b_op_en;
    logic [23:0] b_total;
    logic        b_valid;
    logic [1:0]  b_size;
    logic        b_ig_ready;
    logic        b_dma_valid;
    logic        b_dma_ready;
    logic        b_pop;
    logic        b_done;
    logic [3:0]  b_credit;
    logic [31:0] b_stall;
    logic        b_err;

    int total_cnt;
    int bad_cnt;

    cdp_rdma_credit_sched #(.LAT_DEPTH(256), .CNT_W(9)) u_dut_a (
        .nvdla_core_clk    (clk),
        .nvdla_core_rstn   (rstn_a),
        .reg2dp_op_en      (a_op_en),
        .reg2dp_req_total  (a_total),
        .ig_req_valid      (a_valid),
        .ig_req_size       (a_size),
        .ig_req_ready      (a_ig_ready),
        .dma_req_valid     (a_dma_valid),
        .dma_req_ready     (a_dma_ready),
        .lat_fifo_pop      (a_pop),
        .layer_done        (a_done),
        .credit_cnt        (a_credit),
        .perf_credit_stall (a_stall),
        .credit_err        (a_err)
    );

    cdp_rdma_credit_sched #(.LAT_DEPTH(8), .CNT_W(4)) u_dut_b (
        .nvdla_core_clk    (clk),
        .nvdla_core_rstn   (rstn_b),
        .reg2dp_op_en      (b_op_en),
        .reg2dp_req_total  (b_total),
        .ig_req_valid      (b_valid),
        .ig_req_size       (b_size),
        .ig_req_ready      (b_ig_ready),
        .dma_req_valid     (b_dma_valid),
        .dma_req_ready     (b_dma_ready),
        .lat_fifo_pop      (b_pop),
        .layer_done        (b_done),
        .credit_cnt        (b_credit),
        .perf_credit_stall (b_stall),
        .credit_err        (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op_en;
        logic [23:0] total;
        logic        valid;
        logic [1:0]  size;
        logic        ready;
        logic        pop;
        logic        exp_dv;
        logic        exp_rdy;
        logic [8:0]  exp_cred;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_slot();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_cnt, first_acc, last_acc, done_cnt, done_slot, late_dv;
        logic [8:0] min_cred;

        total_cnt = 0;
        bad_cnt   = 0;

        // op_en toggles; size field is atoms-1; zero-length layer in rows 11-13
        vecs[0]  = '{1'b1, 24'd2, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd256, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 24'd2, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 9'd256, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 24'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 9'd256, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 24'd2, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 9'd256, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 24'd2, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd254, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 24'd2, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd255, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 24'd2, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd256, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 24'd2, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd256, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 24'd2, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd256, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 24'd2, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd256, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 24'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd256, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 24'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd256, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 24'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd256, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 24'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd256, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 24'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd256, 1'b0, 1'b1};

        rstn_a = 1'b0; rstn_b = 1'b0;
        a_op_en = 1'b0; a_total = '0; a_valid = 1'b1; a_size = 2'd0; a_dma_ready = 1'b1; a_pop = 1'b0;
        b_op_en = 1'b0; b_total = '0; b_valid = 1'b1; b_size = 2'd0; b_dma_ready = 1'b1; b_pop = 1'b0;

        // Reset values
        next_slot();
        next_slot();
        chk("rst_a_credit", 32'(a_credit), 32'd256);
        chk("rst_a_dv",     32'(a_dma_valid), 32'd0);
        chk("rst_a_rdy",    32'(a_ig_ready), 32'd0);
        chk("rst_a_done",   32'(a_done), 32'd0);
        chk("rst_a_err",    32'(a_err), 32'd0);
        chk("rst_a_stall",  a_stall, 32'd0);
        chk("rst_b_credit", 32'(b_credit), 32'd8);
        rstn_a = 1'b1; rstn_b = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        next_slot();

        // Table: small layer with backpressure, simultaneous accept+pop,
        // op_en held after done, overflow, zero-length layer
        for (int i = 0; i < 15; i++) begin
            a_op_en     = vecs[i].op_en;
            a_total     = vecs[i].total;
            a_valid     = vecs[i].valid;
            a_size      = vecs[i].size;
            a_dma_ready = vecs[i].ready;
            a_pop       = vecs[i].pop;
            #1;
            chk($sformatf("vec%0d_dv", i),     32'(a_dma_valid), 32'(vecs[i].exp_dv));
            chk($sformatf("vec%0d_rdy", i),    32'(a_ig_ready),  32'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_credit", i), 32'(a_credit),    32'(vecs[i].exp_cred));
            chk($sformatf("vec%0d_done", i),   32'(a_done),      32'(vecs[i].exp_done));
            chk($sformatf("vec%0d_err", i),    32'(a_err),       32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_stall", i),  a_stall,          32'd0);
            next_slot();
        end

        // Single layer: total=4, 4-atom requests, 16 pops starting 10 cycles after first request
        a_op_en = 1'b1; a_total = 24'd4; a_valid = 1'b1; a_size = 2'd3; a_dma_ready = 1'b1; a_pop = 1'b0;
        acc_cnt = 0; first_acc = -1; last_acc = -1; done_cnt = 0; done_slot = -1; late_dv = 0;
        min_cred = 9'd256;
        for (int k = 1; k <= 40; k++) begin
            next_slot();
            a_pop = (k >= 11 && k <= 26);
            #1;
            if (a_credit < min_cred) min_cred = a_credit;
            if (a_dma_valid && a_ig_ready) begin
                acc_cnt++;
                if (first_acc < 0) first_acc = k;
                last_acc = k;
            end
            if (a_done) begin
                done_cnt++;
                done_slot = k;
            end
            if (k > 28 && a_dma_valid) late_dv++;
            if (k == 5)  chk("layer_credit_low", 32'(a_credit), 32'd240);
            if (k == 27) chk("layer_credit_full", 32'(a_credit), 32'd256);
        end
        chk("layer_accepts",   32'(acc_cnt), 32'd4);
        chk("layer_first_acc", 32'(first_acc), 32'd1);
        chk("layer_last_acc",  32'(last_acc), 32'd4);
        chk("layer_min_cred",  32'(min_cred), 32'd240);
        chk("layer_done_cnt",  32'(done_cnt), 32'd1);
        chk("layer_done_slot", 32'(done_slot), 32'd28);
        chk("layer_no_restart_dv", 32'(late_dv), 32'd0);
        chk("layer_err_sticky", 32'(a_err), 32'd1);
        chk("layer_stall",      a_stall, 32'd0);
        a_op_en = 1'b0; a_valid = 1'b0; a_pop = 1'b0;

        // Credit exhaustion on depth-8 instance
        next_slot();
        b_op_en = 1'b1; b_total = 24'd10; b_valid = 1'b1; b_size = 2'd3; b_dma_ready = 1'b1; b_pop = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            next_slot();
            b_pop = (k >= 8 && k <= 11);
            #1;
            if (k == 1 || k == 2) chk($sformatf("exh_acc%0d_dv", k), 32'(b_dma_valid & b_ig_ready), 32'd1);
            if (k == 3) begin
                chk("exh_credit_zero", 32'(b_credit), 32'd0);
                chk("exh_dv_blocked",  32'(b_dma_valid), 32'd0);
            end
            if (k == 8)  chk("exh_stall5", b_stall, 32'd5);
            if (k == 9) begin
                chk("exh_pop1_credit", 32'(b_credit), 32'd1);
                chk("exh_pop1_dv",     32'(b_dma_valid), 32'd0);
            end
            if (k == 11) chk("exh_pop3_dv", 32'(b_dma_valid), 32'd0);
            if (k == 12) begin
                chk("exh_pop4_credit", 32'(b_credit), 32'd4);
                chk("exh_pop4_dv",     32'(b_dma_valid & b_ig_ready), 32'd1);
                chk("exh_stall9",      b_stall, 32'd9);
            end
            if (k == 13) chk("exh_credit_after", 32'(b_credit), 32'd0);
        end

        // Asynchronous reset mid-RUN, checked before any further clock edge
        b_op_en = 1'b0;
        rstn_b  = 1'b0;
        #1;
        chk("arst_credit", 32'(b_credit), 32'd8);
        chk("arst_stall",  b_stall, 32'd0);
        chk("arst_dv",     32'(b_dma_valid), 32'd0);
        chk("arst_rdy",    32'(b_ig_ready), 32'd0);
        chk("arst_done",   32'(b_done), 32'd0);
        chk("arst_err",    32'(b_err), 32'd0);
        next_slot();
        rstn_b = 1'b1;
        next_slot();
        #1;
        chk("arst_post_dv", 32'(b_dma_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/cdp_rdma_credit_sched.md
# cdp_rdma_credit_sched

Layer-level request scheduler for the CDP read DMA. It sits between the read-request generator and the memory-interface request port. It admits each read request only while enough latency-FIFO credits remain. It also counts requests per layer and signals layer completion once every issued atom has been popped from the return latency FIFO.

## Interface
- LAT_DEPTH, 256: latency-FIFO depth in atoms; this is the initial and maximum credit count.
- CNT_W, 9: credit counter width; must satisfy 2^CNT_W > LAT_DEPTH.
- nvdla_core_clk  in  1  core clock; the only clock.
- nvdla_core_rstn  in  1  reset, asynchronous and active-low.
- reg2dp_op_en  in  1  layer enable level; its rising edge starts a layer.
- reg2dp_req_total  in  24  number of read requests in the layer.
- ig_req_valid  in  1  request-generator request valid.
- ig_req_size  in  2  request size in atoms, minus 1 (1..4 atoms).
- ig_req_ready  out  1  request accepted toward the memory interface.
- dma_req_valid  out  1  request valid to the memory interface.
- dma_req_ready  in  1  memory-interface ready.
- lat_fifo_pop  in  1  one atom popped from the latency FIFO; returns one credit.
- layer_done  out  1  single-cycle pulse when the layer is complete.
- credit_cnt  out  CNT_W  current credits, for debug and status.
- perf_credit_stall  out  32  cycles stalled on credits in the current layer.
- credit_err  out  1  sticky flag: a credit was returned while credits were already full.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Start is detected as reg2dp_op_en & ~op_en_d, where op_en_d is reg2dp_op_en registered.
- IDLE -> RUN on start with reg2dp_req_total != 0.
- IDLE -> DRAIN on start with reg2dp_req_total == 0.
- On start: issued counter cleared, perf_credit_stall cleared, reg2dp_req_total latched.
- The gate term is (state==RUN) & (credit_cnt >= ig_req_size+1).
- dma_req_valid = ig_req_valid & gate.
- ig_req_ready = dma_req_ready & gate.
- Accept = ig_req_valid & ig_req_ready.
- On each accept: issued increments by 1.
- RUN -> DRAIN on the accept that makes issued equal to the latched total.
- DRAIN -> DONE when credit_cnt == LAT_DEPTH.
- DONE -> IDLE unconditionally after 1 cycle.
- layer_done = (state==DONE).
- Credit update: credit_next = credit_cnt - (accept ? size+1 : 0) + lat_fifo_pop. All arithmetic is CNT_W+1 bits.
- Simultaneous accept and pop are both applied in the same cycle.
- If the credit result exceeds LAT_DEPTH: saturate at LAT_DEPTH and set credit_err. credit_err clears only on reset.
- Pops are honoured in every state, so credits keep returning in IDLE between layers.
- perf_credit_stall increments when state==RUN & ig_req_valid & credit_cnt < size+1.
- perf_credit_stall saturates at 0xFFFFFFFF and holds its value after the layer ends.
- The request payload bypasses this block; only the valid/ready pair is gated.

## Timing
- Reset values:
  - state = IDLE, credit_cnt = LAT_DEPTH, issued = 0, op_en_d = 0.
  - layer_done = 0, credit_err = 0, perf_credit_stall = 0.
  - dma_req_valid = 0, ig_req_ready = 0.
- Valid/ready gating is combinational: zero-cycle latency from ig to dma.
- State and counters are registered on the rising clock edge.
- dma_req_valid can assert at the earliest in the cycle after the op_en rising edge is sampled.
- A credit returned by pop in cycle N is usable for admission in cycle N+1.
- Once dma_req_valid is asserted it can drop only if state leaves RUN. Credits never decrease without an accept, so valid stays stable under backpressure.
- Minimum layer_done latency after the final pop: 2 cycles (DRAIN sees full credits, then the DONE cycle).
- Reset asserted mid-layer returns the block to reset values immediately. Outstanding credits are lost; software must drain the memory interface before releasing reset.
- An op_en rising edge outside IDLE is ignored. Holding op_en high after done does not restart a layer.

## Test plan
- Single layer:
  - Stimulus: total=4, size=3 each, always ready, each pop returned 10 cycles after its request.
  - Response: 4 accepts on consecutive cycles, credit_cnt falls to 240, then returns to 256; one layer_done pulse 2 cycles after the last pop.
- Credit exhaustion:
  - Stimulus: LAT_DEPTH=8, size=3, no pops.
  - Response: 2 accepts, credit_cnt=0; perf_credit_stall counts every following cycle. The first pop does not admit; the 4th pop admits in the next cycle.
- Simultaneous events:
  - Stimulus: accept of size 1 (size field 0) together with pop in the same cycle.
  - Response: credit_cnt unchanged.
- Overflow:
  - Stimulus: pop while credit_cnt==LAT_DEPTH.
  - Response: credit_cnt stays at LAT_DEPTH, credit_err=1 persists through a later layer.
- Zero-length layer:
  - Stimulus: total=0.
  - Response: no dma_req_valid; layer_done pulses 2 cycles after the start edge.
- Reset mid-RUN and op_en held high:
  - Stimulus: reset asserted during RUN; op_en held high after layer_done.
  - Response: all outputs reach reset values asynchronously; no second layer starts until op_en toggles low then high.
